// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 codes, bus_len encodings, FSM states.
// The LSU_MISALIGN_TRAP_EN build option is consumed in load_store_unit.sv.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Codes with no RV32I meaning, plus unsigned-store codes.
    function automatic logic f3_reserved(input logic store, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension: funct3 + raw right-justified read -> register value.
module lsu_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_funct3)
            LSU_LB:  o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            LSU_LBU: o_data = {24'h0, i_raw[7:0]};
            LSU_LH:  o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            LSU_LHU: o_data = {16'h0, i_raw[15:0]};
            LSU_LW:  o_data = i_raw;
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one bus transaction per request, stretched WAIT_CYCLES extra cycles.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic              rsp_fault,
    output logic              bus_rw,
    output logic [1:0]        bus_len,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_write,
    input  logic [31:0]       bus_read,
    input  logic              bus_exception
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    lsu_state_e        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic              r_bus_rw;
    logic [1:0]        r_bus_len;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_write;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_mis;
    logic              r_rsp_fault;

    logic [1:0]        w_len;
    logic              w_reserved;
    logic              w_skip;
    logic              w_flag;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wmask;
    logic [31:0]       w_ext;
    logic              w_last;

    assign w_len      = req_funct3[1:0];
    assign w_reserved = f3_reserved(req_store, req_funct3);
    assign w_last     = (r_cnt == CNT_W'(WAIT_CYCLES));

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misal;
    assign w_misal = ((w_len == LEN_HALF) && req_addr[0]) ||
                     ((w_len == LEN_WORD) && (req_addr[1:0] != 2'b00));
    assign w_skip  = w_reserved | w_misal;
    assign w_flag  = w_skip;
    assign w_addr  = req_addr;
`else
    // Reserved codes still skip the bus; they just answer with an all-zero response.
    assign w_skip = w_reserved;
    assign w_flag = 1'b0;
    always_comb begin
        w_addr = req_addr;
        if (w_len == LEN_HALF)      w_addr[0]   = 1'b0;
        else if (w_len == LEN_WORD) w_addr[1:0] = 2'b00;
    end
`endif

    always_comb begin
        w_wmask = req_wdata;
        case (w_len)
            LEN_BYTE: w_wmask = {24'h0, req_wdata[7:0]};
            LEN_HALF: w_wmask = {16'h0, req_wdata[15:0]};
            default:  w_wmask = req_wdata;
        endcase
    end

    lsu_extend u_extend (
        .i_funct3 (r_funct3),
        .i_raw    (bus_read),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = w_skip ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (w_last)    w_next = ST_RESP;
            ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus registers are loaded on acceptance and cleared when ACCESS ends, so they are
    // only nonzero while the access is actually in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_bus_rw    <= 1'b0;
            r_bus_len   <= 2'b00;
            r_bus_addr  <= '0;
            r_bus_write <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_mis   <= 1'b0;
            r_rsp_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_store  <= req_store;
                    r_funct3 <= req_funct3;
                    r_cnt    <= '0;
                    if (w_skip) begin
                        r_rsp_mis <= w_flag;
                    end else begin
                        r_bus_rw    <= req_store;
                        r_bus_len   <= w_len;
                        r_bus_addr  <= w_addr;
                        r_bus_write <= w_wmask;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        r_bus_rw    <= 1'b0;
                        r_bus_len   <= 2'b00;
                        r_bus_addr  <= '0;
                        r_bus_write <= 32'h0;
                        r_rsp_fault <= bus_exception;
                        r_rsp_rdata <= (bus_exception || r_store) ? 32'h0 : w_ext;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: if (rsp_ready) begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_mis   <= 1'b0;
                    r_rsp_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign rsp_valid      = (r_state == ST_RESP);
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_misaligned = r_rsp_mis;
    assign rsp_fault      = r_rsp_fault;
    assign bus_rw         = r_bus_rw;
    assign bus_len        = r_bus_len;
    assign bus_addr       = r_bus_addr;
    assign bus_write      = r_bus_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences, random vs. model.
module tb_load_store_unit;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned, rsp_fault;
    logic        bus_rw;
    logic [1:0]  bus_len;
    logic [31:0] bus_addr, bus_write, bus_read;
    logic        bus_exception;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WAIT_CYCLES(WAIT), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
        .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_read(bus_read), .bus_exception(bus_exception)
    );

    typedef struct {
        logic        skip;
        logic        mis;
        logic        rw;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wr;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, br;
        logic        ex;
        int          hold;
        logic [31:0] x_rdata;
        logic        x_mis, x_fault;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: access size from funct3, alignment by modulo, extension by masking.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] br, input logic ex);
        exp_t            e;
        int unsigned     sz;
        longint unsigned mask, v;
        logic            res, misal;
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        res   = (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3[2]);
        misal = (a % sz) != 0;
        e.addr = a;
`ifdef LSU_MISALIGN_TRAP_EN
        e.skip = res || misal;
        e.mis  = e.skip;
`else
        e.skip = res;
        e.mis  = 1'b0;
        e.addr = a - (a % sz);
`endif
        mask  = (64'd1 << (8 * sz)) - 64'd1;
        e.rw  = st;
        e.len = f3[1:0];
        e.wr  = 32'(wd & mask);
        v     = br & mask;
        if (!f3[2] && sz < 4 && v >= (mask + 64'd1) / 2) v = v | ~mask;
        e.rdata = (st || ex) ? 32'h0 : 32'(v);
        e.fault = ex;
        if (e.skip) begin
            e.rdata = 32'h0;
            e.fault = 1'b0;
        end
        return e;
    endfunction

    task automatic run_txn(input string nm, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] br,
                           input logic ex, input int hold, input logic noise,
                           input logic [31:0] x_rdata, input logic x_mis, input logic x_fault);
        exp_t e;
        int   lat, c;
        bit   seen;
        e = model(st, f3, a, wd, br, ex);
        lat = e.skip ? 1 : WAIT + 2;
        @(negedge clk);
        chk({nm, " req_ready idle"}, 96'(req_ready), 96'(1));
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        bus_read = br; bus_exception = ex; rsp_ready = 1'b0;
        @(negedge clk);
        // A second request held during the access must be ignored.
        req_valid = noise;
        if (noise) begin
            req_store = 1'b1; req_funct3 = 3'b010; req_addr = $urandom; req_wdata = $urandom;
        end
        c = 1; seen = 0;
        while (c <= 20 && !seen) begin
            if (rsp_valid) seen = 1;
            else begin
                chk({nm, " bus during access"}, 96'({bus_rw, bus_len, bus_addr, bus_write}),
                    96'({e.rw, e.len, e.addr, e.wr}));
                chk({nm, " req_ready busy"}, 96'(req_ready), 96'(0));
                @(negedge clk);
                c++;
            end
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: no rsp_valid within 20 cycles", nm);
        end
        chk({nm, " latency"}, 96'(c), 96'(lat));
        for (int h = 0; h <= hold; h++) begin
            chk({nm, " rsp fields"}, 96'({rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault}),
                96'({1'b1, x_rdata, x_mis, x_fault}));
            chk({nm, " bus idle in resp"}, 96'({bus_rw, bus_len, bus_addr, bus_write}), 96'(0));
            chk({nm, " req_ready in resp"}, 96'(req_ready), 96'(0));
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, " after release"}, 96'({rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault, req_ready}),
            96'({1'b0, 32'h0, 1'b0, 1'b0, 1'b1}));
    endtask

    task automatic add_vec(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] br, input logic ex, input int hold,
                           input logic [31:0] xr, input logic xm, input logic xf);
        vec_t v;
        v.nm = nm; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.br = br; v.ex = ex; v.hold = hold;
        v.x_rdata = xr; v.x_mis = xm; v.x_fault = xf;
        tv.push_back(v);
    endtask

    initial begin
        exp_t        e;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, br;
        logic        ex;
        logic [2:0]  ld_codes [5];
        ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
        ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;

        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; bus_read = 32'h0; bus_exception = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset state", 96'({req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
                               bus_rw, bus_len, bus_addr, bus_write}),
            96'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0}));
        rst_n = 1'b1;

        add_vec("LB sign",    1'b0, 3'b000, 32'h101, 32'h0,        32'h80,        1'b0, 0, 32'hFFFFFF80, 1'b0, 1'b0);
        add_vec("LBU zero",   1'b0, 3'b100, 32'h101, 32'h0,        32'h80,        1'b0, 0, 32'h00000080, 1'b0, 1'b0);
        add_vec("SW",         1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,         1'b0, 0, 32'h0,        1'b0, 1'b0);
        add_vec("LH sign",    1'b0, 3'b001, 32'h102, 32'h0,        32'h12348001,  1'b0, 0, 32'hFFFF8001, 1'b0, 1'b0);
        add_vec("LHU zero",   1'b0, 3'b101, 32'h102, 32'h0,        32'hFFFF8001,  1'b0, 0, 32'h00008001, 1'b0, 1'b0);
        add_vec("LW hold5",   1'b0, 3'b010, 32'h104, 32'h0,        32'h89ABCDEF,  1'b0, 5, 32'h89ABCDEF, 1'b0, 1'b0);
        add_vec("LW fault",   1'b0, 3'b010, 32'h108, 32'h0,        32'h12345678,  1'b1, 1, 32'h0,        1'b0, 1'b1);
        add_vec("SB fault",   1'b1, 3'b000, 32'h10B, 32'h55,       32'h0,         1'b1, 0, 32'h0,        1'b0, 1'b1);
        add_vec("SH mask",    1'b1, 3'b001, 32'h200, 32'h12345678, 32'h0,         1'b0, 0, 32'h0,        1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        add_vec("LH misalign", 1'b0, 3'b001, 32'h103, 32'h0,       32'h00007FFF,  1'b0, 0, 32'h0,        1'b1, 1'b0);
        add_vec("LW misalign", 1'b0, 3'b010, 32'h106, 32'h0,       32'h1,         1'b0, 0, 32'h0,        1'b1, 1'b0);
        add_vec("reserved 011", 1'b0, 3'b011, 32'h100, 32'h0,      32'h1,         1'b0, 0, 32'h0,        1'b1, 1'b0);
        add_vec("SBU reserved", 1'b1, 3'b100, 32'h100, 32'h1,      32'h0,         1'b0, 0, 32'h0,        1'b1, 1'b0);
`else
        add_vec("LH forced",  1'b0, 3'b001, 32'h103, 32'h0,        32'h00007FFF,  1'b0, 0, 32'h00007FFF, 1'b0, 1'b0);
        add_vec("LW forced",  1'b0, 3'b010, 32'h107, 32'h0,        32'hCAFEF00D,  1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
`endif
        foreach (tv[i])
            run_txn(tv[i].nm, tv[i].st, tv[i].f3, tv[i].a, tv[i].wd, tv[i].br, tv[i].ex,
                    tv[i].hold, 1'b0, tv[i].x_rdata, tv[i].x_mis, tv[i].x_fault);

        // Reset during the access of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h300; req_wdata = 32'h1A5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst mid bus active", 96'({bus_rw, bus_len, bus_addr, bus_write}),
            96'({1'b1, 2'b00, 32'h300, 32'hA5}));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst mid bus cleared", 96'({bus_rw, bus_len, bus_addr, bus_write}), 96'(0));
        chk("rst mid ready/valid", 96'({req_ready, rsp_valid}), 96'({1'b1, 1'b0}));
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst mid no response", 96'({rsp_valid, bus_rw, req_ready}), 96'({1'b0, 1'b0, 1'b1}));
        end

        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            a  = $urandom; wd = $urandom; br = $urandom;
            ex = ($urandom_range(0, 7) == 0);
            e  = model(st, f3, a, wd, br, ex);
            run_txn("random", st, f3, a, wd, br, ex, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    e.rdata, e.mis, e.fault);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
